// File: rtl/button_pulser.sv
// rtl/button_pulser.sv - push-button conditioner: synchronize, debounce, edge-detect, auto-repeat
module button_pulser #(
    parameter int DB_CYCLES    = 4,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 8,
    parameter int CW           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic repeat_en,
    output logic level,
    output logic pulse,
    output logic rel_pulse
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

    logic          s1;
    logic          s;
    logic [CW-1:0] dbc;
    logic [CW-1:0] dbc_next;
    logic [CW-1:0] rpt;
    logic [CW-1:0] rpt_next;
    logic          level_next;
    logic          pulse_next;
    logic          rel_next;
    logic          press;
    logic          release_ev;
    state_t        state;
    state_t        state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= 1'b0;
            s         <= 1'b0;
            dbc       <= '0;
            level     <= 1'b0;
            rpt       <= '0;
            state     <= IDLE;
            pulse     <= 1'b0;
            rel_pulse <= 1'b0;
        end else begin
            s1        <= btn_in;
            s         <= s1;
            dbc       <= dbc_next;
            level     <= level_next;
            rpt       <= rpt_next;
            state     <= state_next;
            pulse     <= pulse_next;
            rel_pulse <= rel_next;
        end
    end

    always_comb begin
        dbc_next   = '0;
        level_next = level;
        state_next = state;
        rpt_next   = rpt;
        pulse_next = 1'b0;
        rel_next   = 1'b0;

        // Any sample matching level leaves dbc_next at zero, restarting the count.
        if (s != level) begin
            if (dbc == DB_LAST) begin
                level_next = s;
            end else begin
                dbc_next = dbc + 1'b1;
            end
        end

        press      = level_next & ~level;
        release_ev = level & ~level_next;

        // Release is checked first so it suppresses a repeat pulse due on the same edge.
        if (release_ev) begin
            state_next = IDLE;
            rpt_next   = '0;
            rel_next   = 1'b1;
        end else if (press) begin
            state_next = HOLD;
            rpt_next   = '0;
            pulse_next = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    rpt_next = '0;
                end
                HOLD: begin
                    if (!repeat_en) begin
                        rpt_next = '0;
                    end else if (rpt == DELAY_LAST) begin
                        rpt_next   = '0;
                        pulse_next = 1'b1;
                        state_next = REPEAT;
                    end else begin
                        rpt_next = rpt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!repeat_en) begin
                        rpt_next   = '0;
                        state_next = HOLD;
                    end else if (rpt == RATE_LAST) begin
                        rpt_next   = '0;
                        pulse_next = 1'b1;
                    end else begin
                        rpt_next = rpt + 1'b1;
                    end
                end
                default: begin
                    rpt_next   = '0;
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_pulser.sv
// tb/tb_button_pulser.sv - self-checking bench for button_pulser
module tb_button_pulser;

    localparam int DB    = 4;
    localparam int DELAY = 16;
    localparam int RATE  = 8;

    logic clk;
    logic rst;
    logic btn;
    logic ren;
    logic level;
    logic pulse;
    logic rel_pulse;

    int errors = 0;
    int checks = 0;
    bit mon_on = 0;

    button_pulser #(
        .DB_CYCLES   (DB),
        .REPEAT_DELAY(DELAY),
        .REPEAT_RATE (RATE),
        .CW          (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn),
        .repeat_en(ren),
        .level    (level),
        .pulse    (pulse),
        .rel_pulse(rel_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level flips once the last DB synchronized samples all
    // disagree with it; repeat pulses come after DELAY, then every RATE, enabled cycles.
    logic m_q1, m_q2, m_lvl, m_p, m_r;
    logic mq[$];
    int   m_mode;
    int   m_run;

    always @(posedge clk or posedge rst) begin : model
        logic s_old;
        logic nl;
        bit   all_diff;
        if (rst) begin
            m_q1 = 0; m_q2 = 0; m_lvl = 0; m_p = 0; m_r = 0;
            mq.delete();
            m_mode = 0; m_run = 0;
        end else begin
            s_old = m_q2;
            m_q2  = m_q1;
            m_q1  = btn;
            mq.push_back(s_old);
            if (mq.size() > DB) void'(mq.pop_front());
            nl = m_lvl;
            if (mq.size() == DB) begin
                all_diff = 1;
                foreach (mq[i]) if (mq[i] == m_lvl) all_diff = 0;
                if (all_diff) begin
                    nl = ~m_lvl;
                    mq.delete();
                end
            end
            m_p = 0;
            m_r = 0;
            if (nl && !m_lvl) begin
                m_p = 1; m_mode = 1; m_run = 0;
            end else if (!nl && m_lvl) begin
                m_r = 1; m_mode = 0; m_run = 0;
            end else if (m_mode != 0) begin
                if (!ren) begin
                    m_mode = 1; m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == ((m_mode == 1) ? DELAY : RATE)) begin
                        m_p = 1; m_mode = 2; m_run = 0;
                    end
                end
            end
            m_lvl = nl;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            chk("model_level", int'(level), int'(m_lvl));
            chk("model_pulse", int'(pulse), int'(m_p));
            chk("model_rel", int'(rel_pulse), int'(m_r));
        end
    end

    task automatic run(input int n, output int np, output int nr);
        np = 0;
        nr = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            np += int'(pulse);
            nr += int'(rel_pulse);
        end
    endtask

    typedef struct {
        logic b;
        logic r;
        int   cycles;
        int   exp_p;
        int   exp_r;
        logic exp_lvl;
    } seg_t;

    seg_t tbl[8];

    initial begin
        int np, nr, first, fall_at;
        tbl[0] = '{1'b1, 1'b0, 3,  0, 0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 10, 0, 0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 20, 1, 0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 10, 0, 1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 60, 6, 0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 10, 1, 1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 10, 0, 0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 4,  0, 0, 1'b0};

        rst = 1; btn = 0; ren = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_level", int'(level), 0);
        chk("reset_pulse", int'(pulse), 0);
        chk("reset_rel", int'(rel_pulse), 0);
        rst = 0;
        mon_on = 1;
        run(5, np, nr);

        foreach (tbl[i]) begin
            btn = tbl[i].b;
            ren = tbl[i].r;
            run(tbl[i].cycles, np, nr);
            chk($sformatf("seg%0d_pulses", i), np, tbl[i].exp_p);
            chk($sformatf("seg%0d_rels", i), nr, tbl[i].exp_r);
            chk($sformatf("seg%0d_level", i), int'(level), int'(tbl[i].exp_lvl));
        end
        btn = 0;
        run(10, np, nr);

        // Bouncy release: level must hold through 2-cycle bounces.
        btn = 1; ren = 0;
        run(20, np, nr);
        chk("bounce_press", np, 1);
        for (int i = 0; i < 6; i++) begin
            int p2, r2;
            btn = (i % 2 == 1);
            run(2, p2, r2);
            chk($sformatf("bounce_lvl%0d", i), int'(level), 1);
            chk($sformatf("bounce_p%0d", i), p2 + r2, 0);
        end
        btn = 0;
        fall_at = -1; np = 0; nr = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!level && fall_at < 0) fall_at = i;
            np += int'(pulse);
            nr += int'(rel_pulse);
        end
        chk("bounce_fall_edge", fall_at, 5);
        chk("bounce_rels", nr, 1);
        chk("bounce_pulses", np, 0);

        // repeat_en drop while in REPEAT, then re-enable.
        btn = 1; ren = 1;
        run(30, np, nr);
        chk("drop_pre_pulses", np, 3);
        ren = 0;
        run(30, np, nr);
        chk("drop_quiet", np, 0);
        ren = 1;
        first = -1;
        for (int i = 0; i < 40 && first < 0; i++) begin
            @(posedge clk);
            #1;
            if (pulse) first = i;
        end
        chk("reenable_delay", first + 1, 16);

        // Async reset mid-REPEAT with the button still held.
        @(posedge clk);
        #3 rst = 1;
        #1;
        chk("arst_level", int'(level), 0);
        chk("arst_pulse", int'(pulse), 0);
        chk("arst_rel", int'(rel_pulse), 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 0;
        first = -1; np = 0; nr = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (pulse && first < 0) first = i;
            np += int'(pulse);
            nr += int'(rel_pulse);
        end
        chk("arst_repress_edge", first, 5);
        chk("arst_repress_count", np, 1);
        chk("arst_no_rel", nr, 0);
        btn = 0;
        run(12, np, nr);

        // Randomized holds of assorted lengths, checked every cycle by the model.
        for (int k = 0; k < 80; k++) begin
            btn = 1'($urandom_range(0, 1));
            ren = ($urandom_range(0, 3) != 0);
            run($urandom_range(1, 30), np, nr);
        end

        mon_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
